// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl
//   Packet sequencer on the read side of the USB receiver byte FIFO. Pops
//   bytes, validates the PID, decodes token address/endpoint, forwards DATA
//   payload through a 2-byte delay buffer so that the CRC16 trailer is never
//   forwarded, checks CRC5/CRC16 and reports one pkt_done pulse per packet.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   r_data, empty     FIFO head byte / FIFO empty
//   rcving, r_error   receiver in-packet flag / receiver framing error
//   r_enable          pop FIFO head at this edge
//   pid, kind, err    packet status, updated with pkt_done
//   tok_addr/endp     token fields, updated with pkt_done
//   d_byte, d_wr      payload byte stream, d_count bytes so far
//   pkt_done          1-cycle end-of-packet strobe
module usb_rx_pkt_ctrl #(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_data,
  input  logic       empty,
  input  logic       rcving,
  input  logic       r_error,
  output logic       r_enable,
  output logic [3:0] pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic [7:0] d_byte,
  output logic       d_wr,
  output logic [6:0] d_count,
  output logic       pkt_done,
  output logic [1:0] kind,
  output logic [3:0] err
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_DATA);

  typedef enum logic [3:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2, S_DATA, S_HEND, S_TEND, S_DRAIN, S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  pid_q;
  logic [1:0]  kind_q;
  logic        rx_e, len_e, crc_e, pid_e;
  logic [7:0]  byte1_q;
  logic [6:0]  addr_q;
  logic [3:0]  endp_q;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [7:0]  buf_old, buf_new;
  logic [1:0]  nbuf;
  logic        pop_state;
  logic        pkt_end;

  // Serial CRCs, bits taken LSB first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[4] ^ d[i]) ? ({r[3:0], 1'b0} ^ 5'h05) : {r[3:0], 1'b0};
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    pop_state = 1'b0;
    case (state)
      S_PID, S_TOK1, S_TOK2, S_DATA, S_HEND, S_TEND, S_DRAIN: pop_state = 1'b1;
      default: pop_state = 1'b0;
    endcase
  end

  // Pop must act on the current head, so it is combinational; rst masks it.
  assign r_enable = !rst && !empty && pop_state;
  // rcving only counts once the FIFO has run dry.
  assign pkt_end  = !rcving && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pid      <= '0;
      tok_addr <= '0;
      tok_endp <= '0;
      d_byte   <= '0;
      d_wr     <= 1'b0;
      d_count  <= '0;
      pkt_done <= 1'b0;
      kind     <= 2'd3;
      err      <= '0;
      pid_q    <= '0;
      kind_q   <= 2'd3;
      {rx_e, len_e, crc_e, pid_e} <= '0;
      byte1_q  <= '0;
      addr_q   <= '0;
      endp_q   <= '0;
      crc5     <= 5'h1F;
      crc16    <= 16'hFFFF;
      buf_old  <= '0;
      buf_new  <= '0;
      nbuf     <= '0;
    end else begin
      d_wr     <= 1'b0;
      pkt_done <= 1'b0;
      if (state != S_IDLE && r_error) rx_e <= 1'b1;
      case (state)
        S_IDLE: if (!empty) begin
          state   <= S_PID;
          d_count <= '0;
          kind_q  <= 2'd3;
          {rx_e, len_e, crc_e, pid_e} <= '0;
          addr_q  <= '0;
          endp_q  <= '0;
          crc5    <= 5'h1F;
          crc16   <= 16'hFFFF;
          nbuf    <= '0;
        end
        S_PID: begin
          if (r_enable) pid_q <= r_data[3:0];
          if (r_error) state <= S_DRAIN;
          else if (r_enable) begin
            if (r_data[7:4] != ~r_data[3:0]) begin
              pid_e <= 1'b1;
              state <= S_DRAIN;
            end else begin
              case (r_data[3:0])
                4'h1, 4'h9, 4'hD, 4'h5: begin kind_q <= 2'd1; state <= S_TOK1; end
                4'h3, 4'hB:             begin kind_q <= 2'd2; state <= S_DATA; end
                4'h2, 4'hA, 4'hE:       begin kind_q <= 2'd0; state <= S_HEND; end
                default:                begin pid_e  <= 1'b1; state <= S_DRAIN; end
              endcase
            end
          end
        end
        S_TOK1: begin
          if (r_error) state <= S_DRAIN;
          else if (r_enable) begin
            byte1_q <= r_data;
            crc5    <= crc5_byte(crc5, r_data);
            state   <= S_TOK2;
          end else if (pkt_end) begin
            // token cut short by the receiver
            len_e <= 1'b1;
            state <= S_DONE;
          end
        end
        S_TOK2: begin
          if (r_error) state <= S_DRAIN;
          else if (r_enable) begin
            addr_q <= byte1_q[6:0];
            endp_q <= {r_data[2:0], byte1_q[7]};
            if (crc5_byte(crc5, r_data) != 5'b01100) crc_e <= 1'b1;
            state  <= S_TEND;
          end else if (pkt_end) begin
            len_e <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DATA: begin
          if (r_error) state <= S_DRAIN;
          else if (r_enable) begin
            crc16   <= crc16_byte(crc16, r_data);
            buf_old <= buf_new;
            buf_new <= r_data;
            if (nbuf == 2'd2) begin
              // oldest byte is now known to be payload, not CRC
              if (d_count == MAX_CNT) begin
                len_e <= 1'b1;
                state <= S_DRAIN;
              end else begin
                d_byte  <= buf_old;
                d_wr    <= 1'b1;
                d_count <= d_count + 7'd1;
              end
            end else begin
              nbuf <= nbuf + 2'd1;
            end
          end else if (pkt_end) begin
            if (nbuf != 2'd2) len_e <= 1'b1;
            if (crc16 != 16'h800D) crc_e <= 1'b1;
            state <= S_TEND;
          end
        end
        S_HEND, S_TEND: begin
          if (r_enable) len_e <= 1'b1;
          else if (pkt_end) state <= S_DONE;
        end
        S_DRAIN: if (pkt_end) state <= S_DONE;
        S_DONE: begin
          pkt_done <= 1'b1;
          pid      <= pid_q;
          kind     <= kind_q;
          err      <= {rx_e | r_error, len_e, crc_e, pid_e};
          tok_addr <= addr_q;
          tok_endp <= endp_q;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Testbench for usb_rx_pkt_ctrl: a byte FIFO model feeds the DUT, a negedge
// monitor captures d_wr bytes and pkt_done status, and a table of packets
// with hand-computed results is replayed, followed by multi-cycle cases.
module tb_usb_rx_pkt_ctrl;
  logic       clk = 1'b0;
  logic       rst, rcving, r_error, flush;
  logic [7:0] r_data;
  logic       empty;
  logic       r_enable, d_wr, pkt_done;
  logic [3:0] pid, tok_endp, err;
  logic [6:0] tok_addr, d_count;
  logic [7:0] d_byte;
  logic [1:0] kind;

  always #5 clk = ~clk;

  usb_rx_pkt_ctrl #(.MAX_DATA(64)) dut (
    .clk(clk), .rst(rst), .r_data(r_data), .empty(empty), .rcving(rcving),
    .r_error(r_error), .r_enable(r_enable), .pid(pid), .tok_addr(tok_addr),
    .tok_endp(tok_endp), .d_byte(d_byte), .d_wr(d_wr), .d_count(d_count),
    .pkt_done(pkt_done), .kind(kind), .err(err)
  );

  // FIFO model
  logic [7:0] mem [256];
  logic [7:0] wr_p = 8'd0;
  logic [7:0] rd_p = 8'd0;
  assign empty  = (rd_p == wr_p);
  assign r_data = mem[rd_p];
  always @(posedge clk)
    if (flush) rd_p <= wr_p;
    else if (r_enable && !empty) rd_p <= rd_p + 8'd1;

  // monitor
  int         n_wr = 0, n_done = 0, viol = 0;
  logic [7:0] cap [512];
  logic [3:0] s_pid, s_err, s_endp;
  logic [1:0] s_kind;
  logic [6:0] s_addr, s_dcount;
  always @(negedge clk) begin
    if (d_wr) begin
      cap[n_wr[8:0]] <= d_byte;
      n_wr <= n_wr + 1;
    end
    if (pkt_done) begin
      n_done   <= n_done + 1;
      s_pid    <= pid;
      s_kind   <= kind;
      s_err    <= err;
      s_addr   <= tok_addr;
      s_endp   <= tok_endp;
      s_dcount <= d_count;
    end
    if (r_enable && empty) viol <= viol + 1;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_p] = b;
    wr_p = wr_p + 8'd1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400; i++) begin
      if (n_done > d0) break;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string           name;
    logic [0:7][7:0] b;
    int              n;
    logic [1:0]      kind;
    logic [3:0]      pid;
    logic [3:0]      err;
    int              nwr;
    bit              chk_tok;
    logic [6:0]      addr;
    logic [3:0]      endp;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v);
    int d0, w0, mism;
    d0 = n_done; w0 = n_wr; mism = 0;
    rcving = 1'b1;
    for (int i = 0; i < v.n; i++) push(v.b[i]);
    rcving = 1'b0;
    wait_done(d0);
    chk({v.name, "_done"}, n_done - d0, 1);
    chk({v.name, "_kind"}, s_kind, v.kind);
    chk({v.name, "_pid"}, s_pid, v.pid);
    chk({v.name, "_err"}, s_err, v.err);
    chk({v.name, "_nwr"}, n_wr - w0, v.nwr);
    chk({v.name, "_dcount"}, s_dcount, v.nwr);
    for (int k = 0; k < v.nwr; k++)
      if (cap[(w0 + k) & 511] !== v.b[1 + k]) mism++;
    chk({v.name, "_payload"}, mism, 0);
    chk({v.name, "_drained"}, (rd_p == wr_p) ? 1 : 0, 1);
    if (v.chk_tok) begin
      chk({v.name, "_addr"}, s_addr, v.addr);
      chk({v.name, "_endp"}, s_endp, v.endp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, w0, mism, pop_cyc, done_cyc;
    // Token CRC5 field sits in byte2[7:3]; for addr 0x3A/endp 1 it is 0,
    // for addr 0/endp 0 it is 5'b00010 (byte2 = 8'h10).
    // DATA CRC16 of 01 02 03 04 is 16'hD45E, sent low byte first.
    vecs[0]  = '{"ack",        {8'hD2, 56'h0}, 1, 2'd0, 4'h2, 4'h0, 0, 1'b0, 7'h00, 4'h0};
    vecs[1]  = '{"out_tok",    {8'hE1, 8'hBA, 8'h00, 40'h0}, 3, 2'd1, 4'h1, 4'h0, 0, 1'b1, 7'h3A, 4'h1};
    vecs[2]  = '{"tok_badcrc", {8'hE1, 8'hBA, 8'h08, 40'h0}, 3, 2'd1, 4'h1, 4'h2, 0, 1'b1, 7'h3A, 4'h1};
    vecs[3]  = '{"data0",      {8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5E, 8'hD4, 8'h00}, 7, 2'd2, 4'h3, 4'h0, 4, 1'b0, 7'h00, 4'h0};
    vecs[4]  = '{"data0_bad",  {8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5E, 8'h2B, 8'h00}, 7, 2'd2, 4'h3, 4'h2, 4, 1'b0, 7'h00, 4'h0};
    vecs[5]  = '{"bad_pid",    {8'hC4, 8'h11, 8'h22, 8'h33, 32'h0}, 4, 2'd3, 4'h4, 4'h1, 0, 1'b0, 7'h00, 4'h0};
    vecs[6]  = '{"ack_extra",  {8'hD2, 8'h55, 48'h0}, 2, 2'd0, 4'h2, 4'h4, 0, 1'b0, 7'h00, 4'h0};
    vecs[7]  = '{"data_short", {8'h4B, 8'h55, 48'h0}, 2, 2'd2, 4'hB, 4'h6, 0, 1'b0, 7'h00, 4'h0};
    vecs[8]  = '{"nak",        {8'h5A, 56'h0}, 1, 2'd0, 4'hA, 4'h0, 0, 1'b0, 7'h00, 4'h0};
    vecs[9]  = '{"in_tok",     {8'h69, 8'hBA, 8'h00, 40'h0}, 3, 2'd1, 4'h9, 4'h0, 0, 1'b1, 7'h3A, 4'h1};
    vecs[10] = '{"setup0",     {8'h2D, 8'h00, 8'h10, 40'h0}, 3, 2'd1, 4'hD, 4'h0, 0, 1'b1, 7'h00, 4'h0};

    rst = 1'b1; rcving = 1'b0; r_error = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_kind", kind, 2'd3);
    chk("rst_pid", pid, 4'h0);
    chk("rst_err", err, 4'h0);
    chk("rst_strobes", {pkt_done, d_wr, r_enable}, 3'b000);
    chk("rst_fields", {tok_addr, tok_endp, d_count, d_byte}, 26'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 11; v++) run_vec(vecs[v]);

    // HSK latency: byte already present, rcving low
    mem[wr_p] = 8'hD2; wr_p = wr_p + 8'd1;
    pop_cyc = -100; done_cyc = 100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_enable) pop_cyc = i;
      if (pkt_done) begin done_cyc = i; break; end
    end
    // pop edge follows the r_enable sample; pkt_done appears two edges later
    chk("hsk_latency", done_cyc - pop_cyc, 3);
    @(negedge clk);
    chk("hsk_done_pulse", pkt_done, 1'b0);
    @(posedge clk); #1;

    // 65-byte DATA1 payload, limit 64
    d0 = n_done; w0 = n_wr; mism = 0;
    rcving = 1'b1;
    push(8'h4B);
    for (int i = 1; i <= 65; i++) push(8'(i));
    push(8'h00); push(8'h00);
    rcving = 1'b0;
    wait_done(d0);
    chk("long_done", n_done - d0, 1);
    chk("long_nwr", n_wr - w0, 64);
    chk("long_dcount", s_dcount, 7'd64);
    chk("long_len_err", s_err[2], 1'b1);
    chk("long_kind", s_kind, 2'd2);
    for (int k = 0; k < 64; k++)
      if (cap[(w0 + k) & 511] !== 8'(k + 1)) mism++;
    chk("long_payload", mism, 0);
    chk("long_drained", (rd_p == wr_p) ? 1 : 0, 1);

    // r_error pulse in the middle of a DATA packet
    d0 = n_done;
    rcving = 1'b1;
    push(8'hC3); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    r_error = 1'b1;
    @(posedge clk); #1;
    r_error = 1'b0;
    push(8'h5E); push(8'hD4);
    rcving = 1'b0;
    wait_done(d0);
    repeat (6) @(posedge clk);
    #1;
    chk("rxerr_done", n_done - d0, 1);
    chk("rxerr_err", s_err, 4'b1000);
    chk("rxerr_kind", s_kind, 2'd2);
    chk("rxerr_drained", (rd_p == wr_p) ? 1 : 0, 1);

    // reset in the middle of a token (upstream FIFO flushed alongside)
    rcving = 1'b1;
    push(8'hE1); push(8'hBA);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; rcving = 1'b0;
    @(negedge clk);
    chk("midrst_kind", kind, 2'd3);
    chk("midrst_pid_err", {pid, err}, 8'h00);
    chk("midrst_fields", {tok_addr, tok_endp, d_count, d_byte}, 26'h0);
    chk("midrst_strobes", {pkt_done, d_wr, r_enable}, 3'b000);
    @(posedge clk); #1;
    run_vec(vecs[0]);

    chk("no_pop_when_empty", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
